// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter with stride advance and branch redirect
//
// Purpose:
//   Holds the fetch address presented to instruction memory. On each rising
//   edge the PC either loads a redirect target, holds for a fetch bubble, or
//   advances by PC_INC. An asynchronous active-low reset forces RESET_VECTOR.
//
// Ports:
//   clk          in   1     system clock, rising-edge active
//   reset        in   1     asynchronous active-low reset
//   stall        in   1     hold the PC this cycle (fetch bubble)
//   branch_instr in   1     load Branch_Addr this cycle (beats stall)
//   Branch_Addr  in   XLEN  redirect target
//   PC_OUT       out  XLEN  current PC (registered)
//   PC_NEXT_SEQ  out  XLEN  PC_OUT + PC_INC, wrapping, for link-register use
//   misaligned   out  1     PC_OUT[1:0] != 0 (informational only)

module program_counter #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
  parameter int unsigned         PC_INC       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_instr,
  input  logic [XLEN-1:0] Branch_Addr,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_NEXT_SEQ,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] STRIDE = XLEN'(PC_INC);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_seq;

  // Sequential successor; the adder truncates to XLEN so the top of the
  // address space wraps to zero without any flag.
  assign pc_seq = pc_q + STRIDE;

  // Redirect wins over stall so a resolved branch is never lost to a bubble.
  always_comb begin
    pc_d = pc_seq;
    if (branch_instr) begin
      pc_d = Branch_Addr;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_OUT      = pc_q;
  assign PC_NEXT_SEQ = pc_seq;
  // Branch targets are loaded unmasked, so low bits may be set; report only.
  assign misaligned  = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter

module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_instr;
  logic [31:0] Branch_Addr;
  logic [31:0] PC_OUT;
  logic [31:0] PC_NEXT_SEQ;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  program_counter dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_instr (branch_instr),
    .Branch_Addr  (Branch_Addr),
    .PC_OUT       (PC_OUT),
    .PC_NEXT_SEQ  (PC_NEXT_SEQ),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        st;
    logic        br;
    logic [31:0] addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Check all three outputs against an expected PC value.
  task automatic check_all(input string name, input logic [31:0] exp_pc);
    logic [31:0] exp_seq;
    exp_seq = exp_pc + 32'd4;
    check32({name, ".pc"}, PC_OUT, exp_pc);
    check32({name, ".seq"}, PC_NEXT_SEQ, exp_seq);
    check1({name, ".mis"}, misaligned, exp_pc[1:0] != 2'b00);
  endtask

  // Drive on the falling edge, then let one rising edge act.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] a);
    @(negedge clk);
    reset        = r;
    stall        = s;
    branch_instr = b;
    Branch_Addr  = a;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_pc;
  logic        r_r, r_s, r_b;
  logic [31:0] r_a;

  initial begin
    // rst, stall, br, addr, expected PC after the edge
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'hAABB_CCDD, 32'hAABB_CCDD};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hAABB_CCE1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0010};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0010};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h0000_001C, 32'h0000_001C};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};

    reset        = 1'b1;
    stall        = 1'b0;
    branch_instr = 1'b0;
    Branch_Addr  = '0;

    // Reset must take effect before any clock edge.
    #2 reset = 1'b0;
    #1;
    check_all("reset_async", 32'h0000_0000);
    @(posedge clk);
    #1;
    check_all("reset_hold", 32'h0000_0000);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst_n, vecs[i].st, vecs[i].br, vecs[i].addr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc);
    end

    // Asynchronous reset between edges at PC=0x20.
    step(1'b1, 1'b0, 1'b1, 32'h0000_001C);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0000);
    check_all("pre_async", 32'h0000_0020);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("mid_async", 32'h0000_0000);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_async", 32'h0000_0004);

    // Randomised run against the rule-level model.
    model_pc = 32'h0000_0004;
    for (int n = 0; n < 2000; n++) begin
      r_r = ($urandom_range(0, 31) != 0);
      r_s = $urandom_range(0, 2) == 0;
      r_b = $urandom_range(0, 3) == 0;
      r_a = $urandom;
      if ($urandom_range(0, 7) == 0) r_a = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      step(r_r, r_s, r_b, r_a);
      if (!r_r)      model_pc = 32'h0000_0000;
      else if (r_b)  model_pc = r_a;
      else if (r_s)  model_pc = model_pc;
      else           model_pc = model_pc + 32'd4;
      if (PC_OUT !== model_pc || PC_NEXT_SEQ !== model_pc + 32'd4 ||
          misaligned !== (model_pc[1:0] != 2'b00)) begin
        check_all($sformatf("rand%0d", n), model_pc);
      end else begin
        checks++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
